// File: rtl/switch_debouncer.sv
// switch_debouncer
// Conditions the board slide switches for the counter datapath. Each raw
// level is brought into the ClockIn domain by a two-flop synchroniser. It is
// then debounced against a shared sample tick. The block produces a clean
// level per channel plus one-cycle rise/fall pulses and a combined Changed
// flag. Every output comes from a flop, so no path runs from RawIn to an
// output without a register in between.
module switch_debouncer #(
  parameter int WIDTH          = 3,
  parameter int TICK_DIV       = 50000,
  parameter int STABLE_SAMPLES = 10
) (
  input  logic             ClockIn,
  input  logic             Reset,
  input  logic [WIDTH-1:0] RawIn,
  output logic [WIDTH-1:0] Clean,
  output logic [WIDTH-1:0] Rise,
  output logic [WIDTH-1:0] Fall,
  output logic             Changed
);

  // Prescaler width is at least one bit. With TICK_DIV == 1 the register
  // stays at zero, so the tick is always asserted.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  // Stability counter only ever reaches STABLE_SAMPLES-1 before it is cleared.
  localparam int CW = $clog2(STABLE_SAMPLES + 1);

  localparam logic [PW-1:0] TICK_LAST   = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_SAMPLES - 1);

  logic [WIDTH-1:0]         sync1_q;
  logic [WIDTH-1:0]         sync2_q;
  logic [PW-1:0]            presc_q, presc_d;
  logic                     tick;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]         clean_q, clean_d;
  logic [WIDTH-1:0]         rise_q, rise_d;
  logic [WIDTH-1:0]         fall_q, fall_d;
  logic                     changed_q, changed_d;

  // Two-flop synchroniser. Only sync2_q is seen by the debounce logic.
  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= RawIn;
      sync2_q <= sync1_q;
    end
  end

  // Sample tick fires on the last count of the prescaler and wraps it to zero.
  always_comb begin
    tick    = (presc_q == TICK_LAST);
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  // Per-channel debounce decision. Partial progress is dropped on any tick
  // that sees the synchronised level agree with Clean. Pulses default to
  // zero so that each one lasts a single ClockIn cycle.
  always_comb begin
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = '0;
    fall_d  = '0;
    if (tick) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2_q[i] == clean_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == STABLE_LAST) begin
          cnt_d[i]   = '0;
          clean_d[i] = sync2_q[i];
          rise_d[i]  = sync2_q[i];
          fall_d[i]  = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    changed_d = |(rise_d | fall_d);
  end

  // State registers for the prescaler, the stability counters and the outputs.
  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      presc_q   <= '0;
      cnt_q     <= '0;
      clean_q   <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      clean_q   <= clean_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end

  assign Clean   = clean_q;
  assign Rise    = rise_q;
  assign Fall    = fall_q;
  assign Changed = changed_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer. Two instances share the same stimulus:
// dut_a uses TICK_DIV=1 and STABLE_SAMPLES=4, and dut_b uses TICK_DIV=3 and
// STABLE_SAMPLES=2. A reference model predicts each instance's outputs per
// clock edge into expected queues. A monitor pops those queues on the falling
// edge and compares them with the DUT outputs.
module tb_switch_debouncer;

  logic       clk;
  logic       rst_in;
  logic [2:0] raw_in;

  logic [2:0] clean_a, rise_a, fall_a;
  logic       changed_a;
  logic [2:0] clean_b, rise_b, fall_b;
  logic       changed_b;

  int n_checks = 0;
  int n_errors = 0;

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  switch_debouncer #(.WIDTH(3), .TICK_DIV(1), .STABLE_SAMPLES(4)) dut_a (
    .ClockIn(clk), .Reset(rst_in), .RawIn(raw_in),
    .Clean(clean_a), .Rise(rise_a), .Fall(fall_a), .Changed(changed_a)
  );

  switch_debouncer #(.WIDTH(3), .TICK_DIV(3), .STABLE_SAMPLES(2)) dut_b (
    .ClockIn(clk), .Reset(rst_in), .RawIn(raw_in),
    .Clean(clean_b), .Rise(rise_b), .Fall(fall_b), .Changed(changed_b)
  );

  // Reference model: raw levels seen two edges late, a sample every
  // t_div-th edge since reset, and Clean flipping after s_samp consecutive
  // differing samples.
  int         t_div [2] = '{1, 3};
  int         s_samp[2] = '{4, 2};
  logic [2:0] m_d1[2];
  logic [2:0] m_d2[2];
  logic [2:0] m_clean[2];
  int         m_n[2];
  int         m_run[2][3];

  // Expected {clean, rise, fall, changed}
  logic [9:0] exp_q_a[$];
  logic [9:0] exp_q_b[$];

  task automatic model_edge(input int k, input logic [2:0] raw, input logic rst);
    logic [2:0] s2;
    logic [2:0] r;
    logic [2:0] f;
    bit         tick;
    r = '0;
    f = '0;
    if (rst) begin
      m_d1[k] = '0;
      m_d2[k] = '0;
      m_clean[k] = '0;
      m_n[k] = 0;
      for (int c = 0; c < 3; c++) m_run[k][c] = 0;
    end else begin
      s2 = m_d2[k];
      tick = ((m_n[k] % t_div[k]) == t_div[k] - 1);
      m_n[k] = m_n[k] + 1;
      m_d2[k] = m_d1[k];
      m_d1[k] = raw;
      if (tick) begin
        for (int c = 0; c < 3; c++) begin
          if (s2[c] != m_clean[k][c]) begin
            m_run[k][c] = m_run[k][c] + 1;
            if (m_run[k][c] == s_samp[k]) begin
              m_clean[k][c] = s2[c];
              m_run[k][c] = 0;
              r[c] = s2[c];
              f[c] = ~s2[c];
            end
          end else begin
            m_run[k][c] = 0;
          end
        end
      end
    end
    if (k == 0) exp_q_a.push_back({m_clean[k], r, f, |(r | f)});
    else        exp_q_b.push_back({m_clean[k], r, f, |(r | f)});
  endtask

  // Driver tasks: apply the inputs for one edge, then advance the model.
  task automatic step(input logic [2:0] raw, input logic rst);
    raw_in = raw;
    rst_in = rst;
    @(posedge clk);
    #1;
    model_edge(0, raw, rst);
    model_edge(1, raw, rst);
  endtask

  task automatic hold(input logic [2:0] raw, input int n);
    repeat (n) step(raw, 1'b0);
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Pulse counters over dut_a, cleared by the driver before each phase.
  logic [2:0] watch_rise = '0;
  int         watch_hits = 0;
  int         changed_hits = 0;

  task automatic clear_watch(input logic [2:0] pat);
    watch_rise   = pat;
    watch_hits   = 0;
    changed_hits = 0;
  endtask

  // Scoreboard monitor: one comparison per instance per edge.
  always @(negedge clk) begin
    logic [9:0] e;
    if (exp_q_a.size() > 0) begin
      e = exp_q_a.pop_front();
      n_checks++;
      if ({clean_a, rise_a, fall_a, changed_a} !== e) begin
        n_errors++;
        $display("FAIL dut_a outputs: got clean=%b rise=%b fall=%b chg=%b expected clean=%b rise=%b fall=%b chg=%b at %0t",
                 clean_a, rise_a, fall_a, changed_a, e[9:7], e[6:4], e[3:1], e[0], $time);
      end
    end
    if (exp_q_b.size() > 0) begin
      e = exp_q_b.pop_front();
      n_checks++;
      if ({clean_b, rise_b, fall_b, changed_b} !== e) begin
        n_errors++;
        $display("FAIL dut_b outputs: got clean=%b rise=%b fall=%b chg=%b expected clean=%b rise=%b fall=%b chg=%b at %0t",
                 clean_b, rise_b, fall_b, changed_b, e[9:7], e[6:4], e[3:1], e[0], $time);
      end
    end
    if (watch_rise != 3'b000 && rise_a == watch_rise) watch_hits++;
    if (changed_a === 1'b1) changed_hits++;
  end

  // Stimulus
  initial begin
    raw_in = '0;
    rst_in = 1'b1;

    // Reset held with all switches high, then released with them still high.
    clear_watch(3'b111);
    repeat (3) step(3'b111, 1'b1);
    hold(3'b111, 12);
    check_int("reset_release_rise111", watch_hits, 1);
    hold(3'b000, 12);

    // Clean step on channel 0, then back down.
    clear_watch(3'b001);
    hold(3'b001, 12);
    check_int("step_rise0_once", watch_hits, 1);
    hold(3'b000, 12);
    check_int("step_changed_twice", changed_hits, 2);

    // Glitch on channel 1, shorter than STABLE_SAMPLES for dut_a.
    clear_watch(3'b010);
    hold(3'b010, 3);
    hold(3'b000, 10);
    check_int("glitch_no_rise", watch_hits, 0);
    check_int("glitch_no_changed", changed_hits, 0);

    // Bounce on channel 2, then settle high.
    clear_watch(3'b100);
    for (int i = 0; i < 3; i++) begin
      hold(3'b100, 2);
      hold(3'b000, 2);
    end
    hold(3'b100, 12);
    check_int("bounce_single_rise", watch_hits, 1);
    check_int("bounce_single_changed", changed_hits, 1);
    hold(3'b000, 12);

    // Simultaneous toggle of channels 0 and 2, then channel 0 alone.
    clear_watch(3'b101);
    hold(3'b101, 12);
    check_int("simul_rise101", watch_hits, 1);
    check_int("simul_changed_once", changed_hits, 1);
    hold(3'b100, 12);
    check_int("indep_clean100", int'(clean_a), 4);
    hold(3'b000, 12);

    // Reset in the middle of a debounce, then a full-latency toggle.
    hold(3'b001, 4);
    step(3'b001, 1'b1);
    hold(3'b001, 12);
    hold(3'b000, 12);

    // Randomised level changes with occasional reset pulses.
    for (int seg = 0; seg < 40; seg++) begin
      logic [2:0] r;
      r = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) step(r, 1'b1);
      hold(r, $urandom_range(1, 12));
    end
    hold(3'b000, 12);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
